// File: rtl/gtxe2_chnl_oob_seq.sv
// Host-side SATA OOB sequencer: COMINIT/COMWAKE exchange, D10.2/ALIGN handshake, link-up hold.
// Latency: Moore FSM; oob_start high in IDLE gives tx_cominit on the following cycle.
// Backpressure: none; waiting states are bounded by TIMEOUT cycles and restart up to MAX_RETRY times.
module gtxe2_chnl_oob_seq #(
  parameter int TIMEOUT   = 4096,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       oob_start,
  input  logic       rx_cominitdet,
  input  logic       rx_comwakedet,
  input  logic       rx_elecidle,
  input  logic       rx_align_det,
  input  logic       rx_sync_det,
  input  logic       tx_comfinish,
  output logic       tx_cominit,
  output logic       tx_comwake,
  output logic       tx_elecidle,
  output logic       tx_send_d10,
  output logic       tx_send_align,
  output logic       link_up,
  output logic       oob_error,
  output logic [3:0] retry_cnt,
  output logic [3:0] state
);

  localparam logic [3:0] S_IDLE           = 4'd0;
  localparam logic [3:0] S_SEND_INIT      = 4'd1;
  localparam logic [3:0] S_WAIT_INIT_TX   = 4'd2;
  localparam logic [3:0] S_WAIT_DEV_INIT  = 4'd3;
  localparam logic [3:0] S_SEND_WAKE      = 4'd4;
  localparam logic [3:0] S_WAIT_WAKE_TX   = 4'd5;
  localparam logic [3:0] S_WAIT_DEV_WAKE  = 4'd6;
  localparam logic [3:0] S_WAIT_RX_ACTIVE = 4'd7;
  localparam logic [3:0] S_SEND_D10       = 4'd8;
  localparam logic [3:0] S_SEND_ALIGN     = 4'd9;
  localparam logic [3:0] S_LINK_UP        = 4'd10;
  localparam logic [3:0] S_ERROR          = 4'd11;

  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  logic [31:0] timer;
  logic [3:0]  nxt_state;
  logic [3:0]  nxt_retry;
  logic        waiting;
  logic        in_seq;
  logic        adv;
  logic [3:0]  adv_state;
  logic        timeout_hit;

  // Classify the current state and pick the advance condition it consumes.
  always_comb begin
    waiting   = 1'b0;
    in_seq    = (state >= S_SEND_INIT) && (state <= S_SEND_ALIGN);
    adv       = 1'b0;
    adv_state = state;
    case (state)
      S_SEND_INIT:      begin adv = 1'b1;          adv_state = S_WAIT_INIT_TX; end
      S_WAIT_INIT_TX:   begin adv = tx_comfinish;  adv_state = S_WAIT_DEV_INIT;  waiting = 1'b1; end
      S_WAIT_DEV_INIT:  begin adv = rx_cominitdet; adv_state = S_SEND_WAKE;      waiting = 1'b1; end
      S_SEND_WAKE:      begin adv = 1'b1;          adv_state = S_WAIT_WAKE_TX; end
      S_WAIT_WAKE_TX:   begin adv = tx_comfinish;  adv_state = S_WAIT_DEV_WAKE;  waiting = 1'b1; end
      S_WAIT_DEV_WAKE:  begin adv = rx_comwakedet; adv_state = S_WAIT_RX_ACTIVE; waiting = 1'b1; end
      S_WAIT_RX_ACTIVE: begin adv = !rx_elecidle;  adv_state = S_SEND_D10;       waiting = 1'b1; end
      S_SEND_D10:       begin adv = rx_align_det;  adv_state = S_SEND_ALIGN;     waiting = 1'b1; end
      S_SEND_ALIGN:     begin adv = rx_sync_det;   adv_state = S_LINK_UP;        waiting = 1'b1; end
      default:          begin adv = 1'b0;          adv_state = state; end
    endcase
    timeout_hit = waiting && (timer == TMO_LAST);
  end

  // Next state and retry count: abort beats advance, advance beats timeout.
  always_comb begin
    nxt_state = state;
    nxt_retry = retry_cnt;
    case (state)
      S_IDLE: begin
        if (oob_start) nxt_state = S_SEND_INIT;
      end
      S_LINK_UP: begin
        // A device COMINIT while linked means it reset; restart from scratch.
        if (rx_cominitdet)   nxt_state = S_SEND_INIT;
        else if (!oob_start) nxt_state = S_IDLE;
      end
      S_ERROR: begin
        if (!oob_start) nxt_state = S_IDLE;
      end
      default: begin
        if (in_seq && !oob_start) begin
          nxt_state = S_IDLE;
        end else if (adv) begin
          nxt_state = adv_state;
        end else if (timeout_hit) begin
          if (retry_cnt == RETRY_MAX) begin
            nxt_state = S_ERROR;
          end else begin
            nxt_state = S_SEND_INIT;
            nxt_retry = retry_cnt + 4'd1;
          end
        end
      end
    endcase
    // The retry budget restarts for a fresh attempt or once the link is held.
    if (nxt_state == S_IDLE || nxt_state == S_LINK_UP) nxt_retry = 4'd0;
    if (state == S_LINK_UP && rx_cominitdet) nxt_retry = 4'd0;
  end

  // State, retry and timer registers; timer runs only while dwelling in a waiting state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      retry_cnt <= 4'd0;
      timer     <= 32'd0;
    end else begin
      state     <= nxt_state;
      retry_cnt <= nxt_retry;
      if (nxt_state != state || !waiting) timer <= 32'd0;
      else                                timer <= timer + 32'd1;
    end
  end

  // Moore output decode.
  always_comb begin
    tx_cominit    = (state == S_SEND_INIT);
    tx_comwake    = (state == S_SEND_WAKE);
    tx_send_d10   = (state == S_SEND_D10);
    tx_send_align = (state == S_SEND_ALIGN);
    link_up       = (state == S_LINK_UP);
    oob_error     = (state == S_ERROR);
    tx_elecidle   = (state <= S_WAIT_RX_ACTIVE) || (state == S_ERROR);
  end

endmodule

// File: tb/tb_gtxe2_chnl_oob_seq.sv
// Directed bench for the OOB sequencer: two instances (TIMEOUT=64/MAX_RETRY=3 and TIMEOUT=16/MAX_RETRY=2).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: none; every wait is bounded and a global watchdog ends the run.
module tb_gtxe2_chnl_oob_seq;

  logic clk = 1'b0;
  logic reset, oob_start, rx_cominitdet, rx_comwakedet, rx_elecidle;
  logic rx_align_det, rx_sync_det, tx_comfinish;

  logic       a_cominit, a_comwake, a_elecidle, a_d10, a_align, a_link, a_err;
  logic [3:0] a_retry, a_state;
  logic       b_cominit, b_comwake, b_elecidle, b_d10, b_align, b_link, b_err;
  logic [3:0] b_retry, b_state;

  int checks   = 0;
  int failures = 0;

  logic       mon_en = 1'b0;
  logic [3:0] last_st;
  logic [3:0] walk[$];
  int         a_cominit_n = 0;
  int         a_comwake_n = 0;
  int         b_cominit_n = 0;

  always #5 clk = ~clk;

  gtxe2_chnl_oob_seq #(.TIMEOUT(64), .MAX_RETRY(3)) dut_a (
    .clk(clk), .reset(reset), .oob_start(oob_start),
    .rx_cominitdet(rx_cominitdet), .rx_comwakedet(rx_comwakedet), .rx_elecidle(rx_elecidle),
    .rx_align_det(rx_align_det), .rx_sync_det(rx_sync_det), .tx_comfinish(tx_comfinish),
    .tx_cominit(a_cominit), .tx_comwake(a_comwake), .tx_elecidle(a_elecidle),
    .tx_send_d10(a_d10), .tx_send_align(a_align), .link_up(a_link), .oob_error(a_err),
    .retry_cnt(a_retry), .state(a_state)
  );

  gtxe2_chnl_oob_seq #(.TIMEOUT(16), .MAX_RETRY(2)) dut_b (
    .clk(clk), .reset(reset), .oob_start(oob_start),
    .rx_cominitdet(rx_cominitdet), .rx_comwakedet(rx_comwakedet), .rx_elecidle(rx_elecidle),
    .rx_align_det(rx_align_det), .rx_sync_det(rx_sync_det), .tx_comfinish(tx_comfinish),
    .tx_cominit(b_cominit), .tx_comwake(b_comwake), .tx_elecidle(b_elecidle),
    .tx_send_d10(b_d10), .tx_send_align(b_align), .link_up(b_link), .oob_error(b_err),
    .retry_cnt(b_retry), .state(b_state)
  );

  // Record the state walk of instance A and count request pulses on the falling edge.
  always @(negedge clk) begin
    if (mon_en && a_state != last_st) begin
      walk.push_back(a_state);
      last_st = a_state;
    end
    if (a_cominit) a_cominit_n++;
    if (a_comwake) a_comwake_n++;
    if (b_cominit) b_cominit_n++;
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulses;
    rx_cominitdet = 1'b0; rx_comwakedet = 1'b0; rx_align_det = 1'b0;
    rx_sync_det = 1'b0; tx_comfinish = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1; oob_start = 1'b0; rx_elecidle = 1'b1;
    clr_pulses();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Apply the stimulus instance A's current state is waiting for, for one cycle.
  task automatic advance_a;
    case (a_state)
      4'd0:       oob_start = 1'b1;
      4'd2, 4'd5: tx_comfinish = 1'b1;
      4'd3:       rx_cominitdet = 1'b1;
      4'd6:       rx_comwakedet = 1'b1;
      4'd7:       rx_elecidle = 1'b0;
      4'd8:       rx_align_det = 1'b1;
      4'd9:       rx_sync_det = 1'b1;
      default:    ;
    endcase
    tick();
    clr_pulses();
  endtask

  task automatic run_to(input logic [3:0] tgt);
    int n = 0;
    while (a_state != tgt && n < 30) begin
      advance_a();
      n++;
    end
    chk("run_to_state", a_state, tgt);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, a_state, 0);
    chk({tag, "_elecidle"}, a_elecidle, 1);
    chk({tag, "_others"}, {a_cominit, a_comwake, a_d10, a_align, a_link, a_err}, 0);
    chk({tag, "_retry"}, a_retry, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_walk[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};

    // Reset state and nominal bring-up with plan timing.
    do_reset();
    chk_reset_outputs("reset");
    walk.delete();
    last_st = 4'hF;
    mon_en = 1'b1;
    a_cominit_n = 0; a_comwake_n = 0;
    oob_start = 1'b1;
    tick();
    chk("nom_send_init", a_state, 1);
    chk("nom_cominit", a_cominit, 1);
    tick();
    repeat (3) tick();
    tx_comfinish = 1'b1; tick(); clr_pulses();
    chk("nom_wait_dev_init", a_state, 3);
    repeat (9) tick();
    rx_cominitdet = 1'b1; tick(); clr_pulses();
    chk("nom_send_wake", a_state, 4);
    chk("nom_comwake", a_comwake, 1);
    tick();
    repeat (3) tick();
    tx_comfinish = 1'b1; tick(); clr_pulses();
    chk("nom_wait_dev_wake", a_state, 6);
    repeat (9) tick();
    rx_comwakedet = 1'b1; tick(); clr_pulses();
    chk("nom_wait_rx_active", a_state, 7);
    repeat (2) tick();
    rx_elecidle = 1'b0; tick();
    chk("nom_send_d10", a_state, 8);
    chk("nom_d10_on", a_d10, 1);
    chk("nom_d10_elecidle", a_elecidle, 0);
    repeat (3) tick();
    rx_align_det = 1'b1; tick(); clr_pulses();
    chk("nom_send_align", a_state, 9);
    chk("nom_align_on", a_align, 1);
    tick();
    rx_sync_det = 1'b1; tick(); clr_pulses();
    chk("nom_link_state", a_state, 10);
    chk("nom_link_up", a_link, 1);
    chk("nom_link_retry", a_retry, 0);
    chk("nom_link_elecidle", a_elecidle, 0);
    tick();
    mon_en = 1'b0;
    chk("nom_walk_len", walk.size(), 11);
    for (int i = 0; i < 11 && i < walk.size(); i++) chk("nom_walk", walk[i], exp_walk[i]);
    chk("nom_cominit_pulses", a_cominit_n, 1);
    chk("nom_comwake_pulses", a_comwake_n, 1);

    // Retry exhaustion on instance B (TIMEOUT=16, MAX_RETRY=2).
    do_reset();
    b_cominit_n = 0;
    oob_start = 1'b1;
    tick();
    chk("rx_b_send_init", b_state, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (b_state == 4'd2 && n < 100) begin
        n++;
        tick();
      end
      chk("rx_b_wait_cycles", n, 16);
      if (k < 2) begin
        chk("rx_b_restart", b_state, 1);
        chk("rx_b_retry", b_retry, k + 1);
        tick();
      end else begin
        chk("rx_b_error_state", b_state, 11);
        chk("rx_b_oob_error", b_err, 1);
        chk("rx_b_error_retry", b_retry, 2);
      end
    end
    chk("rx_b_cominit_pulses", b_cominit_n, 3);
    oob_start = 1'b0;
    tick();
    chk("rx_b_idle", b_state, 0);
    chk("rx_b_idle_retry", b_retry, 0);
    chk("rx_b_idle_err", b_err, 0);

    // Advance and timeout in the same cycle of SEND_D10, then a plain timeout from SEND_ALIGN.
    do_reset();
    run_to(4'd8);
    repeat (63) tick();
    chk("same_still_d10", a_state, 8);
    rx_align_det = 1'b1; tick(); clr_pulses();
    chk("same_send_align", a_state, 9);
    chk("same_retry", a_retry, 0);
    repeat (63) tick();
    chk("tmo_still_align", a_state, 9);
    tick();
    chk("tmo_restart", a_state, 1);
    chk("tmo_retry", a_retry, 1);

    // Abort in WAIT_DEV_WAKE coincident with COMWAKE, after one retry.
    do_reset();
    run_to(4'd2);
    repeat (64) tick();
    chk("abort_pre_retry", a_retry, 1);
    run_to(4'd6);
    oob_start = 1'b0; rx_comwakedet = 1'b1; tick(); clr_pulses();
    chk("abort_idle", a_state, 0);
    chk("abort_elecidle", a_elecidle, 1);
    chk("abort_retry", a_retry, 0);

    // Device COMINIT while linked.
    do_reset();
    run_to(4'd2);
    repeat (64) tick();
    chk("devrst_pre_retry", a_retry, 1);
    run_to(4'd10);
    chk("devrst_linked", a_link, 1);
    chk("devrst_link_retry", a_retry, 0);
    rx_cominitdet = 1'b1; tick(); clr_pulses();
    chk("devrst_state", a_state, 1);
    chk("devrst_cominit", a_cominit, 1);
    chk("devrst_link_down", a_link, 0);
    chk("devrst_retry", a_retry, 0);

    // Reset mid-operation in SEND_ALIGN.
    run_to(4'd9);
    repeat (5) tick();
    chk("rst_mid_in_align", a_state, 9);
    reset = 1'b1; tick();
    chk_reset_outputs("rst_mid");
    chk("rst_mid_timer", int'(dut_a.timer), 0);
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gtxe2_chnl_oob_seq.md
Name: gtxe2_chnl_oob_seq

Overview:
Host-side SATA OOB link-initialization sequencer that drives the GTXE2 channel's TX OOB requests and consumes the RX OOB detector outputs (COMINIT/COMWAKE detect, electrical idle).
It sequences COMINIT, COMWAKE, D10.2 and ALIGN exchange up to link-up, with per-state timeout and bounded retry.
It sits between the channel model and the link layer. It is a Moore FSM, so every output is decoded from registered state.

Parameters:
TIMEOUT, 4096, maximum cycles spent in any waiting state (must be >= 2).
MAX_RETRY, 3, number of restarts from SEND_INIT before ERROR (0..15).

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
oob_start  input  1  level request: run OOB and hold the link; deassert to abort or drop the link
rx_cominitdet  input  1  device COMINIT detected (pulse, from RX OOB detector)
rx_comwakedet  input  1  device COMWAKE detected (pulse, from RX OOB detector)
rx_elecidle  input  1  RX line in electrical idle
rx_align_det  input  1  ALIGN primitive received this cycle
rx_sync_det  input  1  SYNC primitive received this cycle
tx_comfinish  input  1  TX OOB burst sequence complete (pulse)
tx_cominit  output  1  request COMINIT burst
tx_comwake  output  1  request COMWAKE burst
tx_elecidle  output  1  force TX electrical idle
tx_send_d10  output  1  transmit D10.2 stream
tx_send_align  output  1  transmit ALIGN primitives
link_up  output  1  link established
oob_error  output  1  retries exhausted
retry_cnt  output  4  retries used in current attempt
state  output  4  current state encoding (debug)

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-high.
  - Reset gives state=IDLE(0), timer=0, retry_cnt=0.
  - Outputs after reset: tx_elecidle=1, all other outputs 0.
- Encodings and transitions:
  - IDLE(0): oob_start=1 -> SEND_INIT.
  - SEND_INIT(1): held exactly 1 cycle with tx_cominit=1 -> WAIT_INIT_TX.
  - WAIT_INIT_TX(2): tx_comfinish -> WAIT_DEV_INIT.
  - WAIT_DEV_INIT(3): rx_cominitdet -> SEND_WAKE.
  - SEND_WAKE(4): held exactly 1 cycle with tx_comwake=1 -> WAIT_WAKE_TX.
  - WAIT_WAKE_TX(5): tx_comfinish -> WAIT_DEV_WAKE.
  - WAIT_DEV_WAKE(6): rx_comwakedet -> WAIT_RX_ACTIVE.
  - WAIT_RX_ACTIVE(7): rx_elecidle=0 -> SEND_D10.
  - SEND_D10(8): tx_send_d10=1. rx_align_det -> SEND_ALIGN.
  - SEND_ALIGN(9): tx_send_align=1. rx_sync_det -> LINK_UP.
  - LINK_UP(10): link_up=1.
    - rx_cominitdet -> SEND_INIT and retry_cnt:=0.
    - oob_start=0 -> IDLE.
  - ERROR(11): oob_error=1. oob_start=0 -> IDLE.
- Output decode:
  - tx_elecidle=1 in states 0-7 and 11; 0 in states 8-10.
  - Outputs not listed for a state are 0.
- Latency: oob_start sampled high in IDLE means tx_cominit is high in the next cycle.
- Transition priority per cycle: reset > abort > advance condition > timeout.
  - Abort: oob_start=0 in states 1-9 -> IDLE.
  - Advance wins over timeout when both occur in the same cycle.
- Timer:
  - 32-bit. Cleared on every state change, and held at 0 in states 0, 1, 4, 10 and 11.
  - Otherwise increments by 1 per cycle.
  - Timeout fires when timer == TIMEOUT-1 in states 2, 3, 5, 6, 7, 8, 9. A waiting state therefore lasts at most TIMEOUT cycles.
- On timeout:
  - retry_cnt == MAX_RETRY -> ERROR, retry_cnt held.
  - Otherwise retry_cnt := retry_cnt+1 -> SEND_INIT.
- retry_cnt is cleared in IDLE, on entry to LINK_UP, and on COMINIT in LINK_UP.
- Ignored inputs:
  - rx_cominitdet, rx_comwakedet and tx_comfinish are ignored outside the states that consume them.
  - An early rx_comwakedet during WAIT_WAKE_TX is lost; the FSM waits for the next one.
- Reset mid-sequence returns to IDLE in 1 cycle regardless of state.

Test Plan:
- Nominal bring-up, TIMEOUT=64. Stimulus: start=1; comfinish 5 cycles later; cominitdet +10; comfinish +5; comwakedet +10; rx_elecidle falls +3; align_det +4; sync_det +2.
  Required: state walks 0,1,2,3,4,5,6,7,8,9,10; tx_cominit and tx_comwake each high exactly 1 cycle; link_up=1; retry_cnt=0; tx_elecidle=0 from SEND_D10 onward.
- Retry exhaustion, TIMEOUT=16, MAX_RETRY=2, no device response. Stimulus: start=1, no responses.
  Required: 3 tx_cominit pulses, each followed by exactly 16 cycles in WAIT_DEV_INIT... the first waiting state reached is WAIT_INIT_TX, so the cycle count applies there (16 cycles each); retry_cnt goes 1, 2; then ERROR with oob_error=1 and retry_cnt=2; start=0 -> IDLE with retry_cnt=0.
- Same-cycle advance and timeout. Stimulus: rx_align_det asserted exactly when the SEND_D10 timer equals TIMEOUT-1.
  Required: next state SEND_ALIGN; retry_cnt unchanged.
- Abort. Stimulus: oob_start dropped in WAIT_DEV_WAKE, coincident with rx_comwakedet.
  Required: IDLE next cycle; tx_elecidle=1; retry_cnt=0.
- Device reset while linked. Stimulus: in LINK_UP with retry_cnt previously 1, pulse rx_cominitdet.
  Required: SEND_INIT next cycle; tx_cominit=1; link_up=0; retry_cnt=0.
- Reset mid-operation. Stimulus: reset asserted for 1 cycle during SEND_ALIGN.
  Required: IDLE next cycle; all outputs at reset values; timer=0.
